// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV/CTRL registers,
// a small TX FIFO, a bit-timed serialiser and a drain interrupt.
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module mmio_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd434
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [`API_ADDR_WIDTH-1:0] address_i,
    input  logic [`API_DATA_WIDTH-1:0] data_in_i,
    input  logic [3:0]                 wr_mask_i,
    output logic [`API_DATA_WIDTH-1:0] data_out_o,
    output logic                       tx_o,
    output logic                       irq_o
);
    localparam int DW = `API_DATA_WIDTH;
    localparam int AW = `API_ADDR_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_BAUD   = 2'd2;
    localparam logic [1:0] A_CTRL   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [15:0]   r_baud;
    logic [1:0]    r_ctrl;
    logic          r_irq;
    logic [DW-1:0] r_rdata;
    logic [15:0]   r_div;
    logic [15:0]   r_bit_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;

    logic          w_wr;
    logic          w_rd;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_bit_done;
    logic [3:0]    w_level;
    logic [DW-1:0] w_rd_value;
    logic          w_unused_bits;

    assign w_wr       = en && (wr_mask_i != 4'b0000);
    assign w_rd       = en && (wr_mask_i == 4'b0000);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_level    = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);
    assign w_push     = w_wr && (address_i[3:2] == A_TXDATA) && wr_mask_i[0];
    assign w_pop      = (r_state == S_IDLE) && r_ctrl[0] && !w_empty;
    // A push into a full FIFO still lands when the serialiser frees a slot in the same cycle.
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_bit_done = (r_bit_cnt == r_div - 16'd1);

    assign w_unused_bits = ^{address_i[AW-1:4], address_i[1:0], data_in_i[DW-1:16]};

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= data_in_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PW'(1);
            if (w_pop)     r_rptr <= r_rptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf  <= 1'b0;
            r_baud <= DIV_RST;
            r_ctrl <= 2'b00;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (address_i[3:2] == A_STATUS) && wr_mask_i[0] && data_in_i[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr && (address_i[3:2] == A_BAUD)) begin
                if (wr_mask_i[0]) r_baud[7:0]  <= data_in_i[7:0];
                if (wr_mask_i[1]) r_baud[15:8] <= data_in_i[15:8];
            end
            if (w_wr && (address_i[3:2] == A_CTRL) && wr_mask_i[0]) begin
                r_ctrl <= data_in_i[1:0];
            end
        end
    end

    always_comb begin
        w_rd_value = '0;
        case (address_i[3:2])
            A_STATUS: w_rd_value = DW'({w_level, r_ovf, w_busy, w_empty, w_full});
            A_BAUD:   w_rd_value = DW'(r_baud);
            A_CTRL:   w_rd_value = DW'(r_ctrl);
            default:  w_rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_rd) r_rdata <= w_rd_value;
            r_irq <= r_ctrl[1] && w_empty && !w_busy;
        end
    end

    assign data_out_o = r_rdata;
    assign irq_o      = r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop) w_state_next = S_START;
            S_START: if (w_bit_done) w_state_next = S_DATA;
            S_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_bit_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        if (r_state == S_START) begin
            tx_o = 1'b0;
        end else if (r_state == S_DATA) begin
            tx_o = r_shift[0];
        end
    end

    // The divisor is frozen at pop so BAUDDIV writes never stretch a frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_div     <= 16'd1;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rptr];
            r_div     <= (r_baud == 16'd0) ? 16'd1 : r_baud;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_bit_done) begin
                r_bit_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, framing, FIFO overflow,
// back-to-back frames, interrupt timing, divisor latching and resets.
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] address_i = '0;
    logic [31:0] data_in_i = '0;
    logic [3:0]  wr_mask_i = '0;
    logic [31:0] data_out_o;
    logic        tx_o;
    logic        irq_o;

    int total = 0;
    int bad = 0;

    logic       tx_log  [0:1023];
    logic [7:0] st_log  [0:1023];
    logic       irq_log [0:1023];

    mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_RST(16'd434)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .address_i(address_i),
        .data_in_i(data_in_i), .wr_mask_i(wr_mask_i), .data_out_o(data_out_o),
        .tx_o(tx_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        en = 1'b1; address_i = a; data_in_i = d; wr_mask_i = m;
        @(posedge clk); #1;
        en = 1'b0; wr_mask_i = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1; address_i = a; wr_mask_i = 4'b0000;
        @(posedge clk); #1;
        en = 1'b0;
        d = data_out_o;
    endtask

    // Holds a STATUS read every cycle; st_log[k] shows the state one cycle before tx_log[k].
    task automatic watch_status(input int n);
        en = 1'b1; address_i = 32'h4; wr_mask_i = 4'b0000;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            tx_log[k]  = tx_o;
            st_log[k]  = data_out_o[7:0];
            irq_log[k] = irq_o;
        end
        en = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int r, input int div);
        int idx;
        idx = r / div;
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx_o); end
        total++; if (data_out_o !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h expected 0", data_out_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        @(negedge clk); reset_n = 1'b1;
        bus_read(32'h4, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL reset_status: got %h expected 2", d); end
        bus_read(32'h8, d);
        total++; if (d !== 32'd434) begin bad++; $display("FAIL reset_baud: got %0d expected 434", d); end
        bus_read(32'hC, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        bus_write(32'h8, 32'h0000_1234, 4'b0010);
        bus_read(32'h8, d);
        total++; if (d !== 32'h12B2) begin bad++; $display("FAIL baud_lane1: got %h expected 12b2", d); end
        bus_write(32'h8, 32'hFFFF_0056, 4'b1101);
        bus_read(32'h8, d);
        total++; if (d !== 32'h1256) begin bad++; $display("FAIL baud_lane0: got %h expected 1256", d); end
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b0010);
        bus_read(32'hC, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_lane1_ignored: got %h expected 0", d); end
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b0001);
        bus_read(32'hC, d);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL ctrl_write: got %h expected 3", d); end
        bus_write(32'hC, 32'h0, 4'b0001);
        bus_read(32'h0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL txdata_read: got %h expected 0", d); end
        bus_read(32'h4, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL read_no_push: got %h expected 2", d); end
    endtask

    task automatic test_single_frame;
        int nb;
        bus_write(32'h8, 32'd4, 4'b0011);
        bus_write(32'hC, 32'h1, 4'b0001);
        bus_write(32'h0, 32'hA5, 4'b0001);
        watch_status(60);
        for (int k = 0; k < 60; k++) begin
            total++;
            if (tx_log[k] !== ((k < 40) ? frame_bit(8'hA5, k, 4) : 1'b1)) begin
                bad++; $display("FAIL frame_a5 cycle %0d: got %b expected %b", k, tx_log[k],
                                (k < 40) ? frame_bit(8'hA5, k, 4) : 1'b1);
            end
        end
        nb = 0;
        for (int k = 0; k < 60; k++) if (st_log[k][2] === 1'b1) nb++;
        total++; if (nb != 40) begin bad++; $display("FAIL busy_len: got %0d expected 40", nb); end
        total++; if (st_log[0][2] !== 1'b0 || st_log[1][2] !== 1'b1) begin
            bad++; $display("FAIL busy_start: got %b%b expected 01", st_log[0][2], st_log[1][2]);
        end
    endtask

    task automatic test_fill_overflow;
        logic [31:0] d;
        bus_write(32'hC, 32'h0, 4'b0001);
        bus_write(32'h0, 32'h1, 4'b0001);
        bus_read(32'h4, d);
        total++; if (d !== 32'h10) begin bad++; $display("FAIL fill_one: got %h expected 10", d); end
        for (int i = 2; i <= 9; i++) bus_write(32'h0, 32'(i), 4'b0001);
        bus_read(32'h4, d);
        total++; if (d !== 32'h89) begin bad++; $display("FAIL fill_overflow: got %h expected 89", d); end
        bus_write(32'h4, 32'h8, 4'b0001);
        bus_read(32'h4, d);
        total++; if (d !== 32'h81) begin bad++; $display("FAIL ovf_clear: got %h expected 81", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        int nb;
        bus_write(32'hC, 32'h1, 4'b0001);
        watch_status(333);
        for (int j = 0; j < 8; j++) begin
            for (int r = 0; r < 40; r++) begin
                total++;
                if (tx_log[41*j + r] !== frame_bit(8'(j + 1), r, 4)) begin
                    bad++; $display("FAIL b2b frame %0d cycle %0d: got %b expected %b", j, r,
                                    tx_log[41*j + r], frame_bit(8'(j + 1), r, 4));
                end
            end
            if (j < 7) begin
                total++;
                if (st_log[41*j + 41][2] !== 1'b0 || tx_log[41*j + 41] !== 1'b0) begin
                    bad++; $display("FAIL b2b gap %0d: got busy=%b tx=%b expected busy=0 tx=0", j,
                                    st_log[41*j + 41][2], tx_log[41*j + 41]);
                end
            end
        end
        nb = 0;
        for (int k = 0; k < 333; k++) if (st_log[k][2] === 1'b1) nb++;
        total++; if (nb != 320) begin bad++; $display("FAIL b2b_busy: got %0d expected 320", nb); end
        bus_read(32'h4, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL b2b_status: got %h expected 2", d); end
    endtask

    task automatic test_irq;
        bus_write(32'hC, 32'h3, 4'b0001);
        repeat (2) @(posedge clk);
        #1;
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_idle: got %b expected 1", irq_o); end
        bus_write(32'h0, 32'h3C, 4'b0001);
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_push_edge: got %b expected 1", irq_o); end
        watch_status(50);
        for (int k = 0; k < 50; k++) begin
            total++;
            if (irq_log[k] !== ((k >= 41) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL irq cycle %0d: got %b expected %b", k, irq_log[k], (k >= 41));
            end
        end
        total++; if (st_log[41][2] !== 1'b0 || st_log[40][2] !== 1'b1) begin
            bad++; $display("FAIL irq_busy_fall: got %b%b expected 10", st_log[40][2], st_log[41][2]);
        end
    endtask

    task automatic test_div_change;
        logic [31:0] d;
        logic exp;
        bus_write(32'h0, 32'h55, 4'b0001);
        bus_write(32'h0, 32'hC3, 4'b0001);
        bus_write(32'h8, 32'd8, 4'b0011);
        bus_read(32'h8, d);
        total++; if (d !== 32'd8) begin bad++; $display("FAIL baud_readback: got %0d expected 8", d); end
        watch_status(130);
        for (int k = 0; k < 130; k++) begin
            if (k <= 36) exp = frame_bit(8'h55, k + 3, 4);
            else if (k == 37) exp = 1'b1;
            else if (k <= 117) exp = frame_bit(8'hC3, k - 38, 8);
            else exp = 1'b1;
            total++;
            if (tx_log[k] !== exp) begin
                bad++; $display("FAIL divchg cycle %0d: got %b expected %b", k, tx_log[k], exp);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] d;
        int nb;
        bus_write(32'h8, 32'd0, 4'b0011);
        bus_read(32'h8, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL baud_zero_read: got %0d expected 0", d); end
        bus_write(32'h0, 32'hF0, 4'b0001);
        watch_status(20);
        for (int k = 0; k < 12; k++) begin
            total++;
            if (tx_log[k] !== frame_bit(8'hF0, k, 1)) begin
                bad++; $display("FAIL div0 cycle %0d: got %b expected %b", k, tx_log[k], frame_bit(8'hF0, k, 1));
            end
        end
        nb = 0;
        for (int k = 0; k < 20; k++) if (st_log[k][2] === 1'b1) nb++;
        total++; if (nb != 10) begin bad++; $display("FAIL div0_busy: got %0d expected 10", nb); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        bus_write(32'h8, 32'd4, 4'b0011);
        bus_write(32'h0, 32'h00, 4'b0001);
        watch_status(12);
        total++; if (tx_log[11] !== 1'b0) begin bad++; $display("FAIL midframe_low: got %b expected 0", tx_log[11]); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL async_reset_tx: got %b expected 1", tx_o); end
        total++; if (data_out_o !== 32'h0) begin bad++; $display("FAIL async_reset_dout: got %h expected 0", data_out_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL async_reset_irq: got %b expected 0", irq_o); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        bus_read(32'h4, d);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL post_reset_status: got %h expected 2", d); end
        bus_read(32'h8, d);
        total++; if (d !== 32'd434) begin bad++; $display("FAIL post_reset_baud: got %0d expected 434", d); end
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL post_reset_tx: got %b expected 1", tx_o); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_single_frame();
        test_fill_overflow();
        test_back_to_back();
        test_irq();
        test_div_change();
        test_div_zero();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
